load_store_unit: RTL
====================

# load_store_unit

Memory-access stage of the 8-bit RISC pipeline, sitting directly upstream of the 256-byte data memory. Accepts one load/store request at a time from the execute stage via valid/ready. Sequences 8-bit and 16-bit little-endian accesses as single-byte memory cycles and returns load results to write-back via valid/ready. All memory-side outputs are registered, so they are stable at the memory's falling-edge capture.

## Interface
Parameters:
- ADDR_W, 8, data-memory address width (256 bytes)
- REG_W, 3, destination-register index width

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  execute stage presents a request
- req_ready  out  1  unit can accept; equals (state == IDLE)
- req_op  in  2  00 LB, 01 SB, 10 LH, 11 SH
- req_addr  in  ADDR_W  byte address of the low byte
- req_wdata  in  16  store data; SB uses [7:0]
- req_rd  in  REG_W  destination register for loads
- rsp_valid  out  1  load result available
- rsp_ready  in  1  write-back stage accepts the result
- rsp_data  out  16  load data; LB zero-extends to 16
- rsp_rd  out  REG_W  destination register of the result
- mem_write  out  1  to memory write input; 1 = write, 0 = read
- mem_address  out  ADDR_W  to memory address input
- mem_datain  out  8  to memory write-data input
- mem_dataout  in  8  from memory; valid before the rising edge that ends the cycle in which mem_address was presented

## Operation
- States: IDLE, BYTE0, BYTE1, RESP.
- IDLE:
  - On req_valid & req_ready, latch op, addr, wdata and rd.
  - Register mem_address = req_addr, mem_write = op[0], and mem_datain = req_wdata[7:0].
  - Go to BYTE0.
- BYTE0: memory performs the low-byte access this cycle. At the end of the cycle:
  - Loads capture mem_dataout into data[7:0].
  - Halfword ops: mem_address = addr+1 (mod 256, so 0xFF wraps to 0x00), mem_datain = wdata[15:8], mem_write held; go to BYTE1.
  - Byte ops: mem_write = 0; loads go to RESP, stores go to IDLE.
- BYTE1: loads capture mem_dataout into data[15:8]. mem_write = 0. Loads go to RESP, stores go to IDLE.
- RESP:
  - rsp_valid = 1; rsp_data and rsp_rd held stable.
  - On rsp_ready, go to IDLE, with rsp_valid = 0 next cycle.
- Stores produce no response.
- Byte order is little-endian: the low byte is at addr.
- mem_write is 1 only while in BYTE0/BYTE1 of a store. In IDLE and RESP, mem_address holds its last value with mem_write = 0; the resulting reads are harmless.
- Requests in any state other than IDLE are not accepted. req_valid is held by the upstream stage.

## Timing
- Reset values:
  - state = IDLE
  - mem_write = 0, mem_address = 0, mem_datain = 0
  - rsp_valid = 0, rsp_data = 0, rsp_rd = 0
- req_ready is combinational from state. Requests presented during a reset cycle are ignored.
- Acceptance edge is E0. Then:
  - LB: rsp_valid is high from E1.
  - LH: rsp_valid is high from E2.
  - SB: byte written at the falling edge between E0 and E1; req_ready is high again from E1.
  - SH: bytes written between E0–E1 and E1–E2; req_ready is high again from E2.
- Back-to-back throughput:
  - SB: one request per 2 cycles.
  - LB with rsp_ready tied high: one request per 3 cycles.
- Reset mid-operation: a write whose cycle began before the reset edge completes, because mem_write was already registered. No further byte is written. Any pending response is dropped.
- Load after store to the same address sees the new data, because the store completes before IDLE is re-entered.

## Structure
- Shared package lsu_pkg holds:
  - op encodings LSU_LB, LSU_SB, LSU_LH, LSU_SH
  - state enum IDLE/BYTE0/BYTE1/RESP
  - constant MEM_DEPTH = 256
- No sub-module. The FSM and byte-lane registers are a single module.
- The memory stage top instantiates load_store_unit next to the data memory.

## Test plan
- Reset, then SB addr 0x10 wdata 0x00A5; LB 0x10, rd=3 -> rsp_data 0x00A5, rsp_rd 3, rsp_valid 1 cycle after LB acceptance.
- SH addr 0x20 wdata 0xBEEF -> mem[0x20] = 0xEF, mem[0x21] = 0xBE; LH 0x20 -> rsp_data 0xBEEF, rsp_valid 2 cycles after acceptance.
- SH addr 0xFF wdata 0x1234 -> mem[0xFF] = 0x34, mem[0x00] = 0x12 (wrap); LH 0xFF -> 0x1234.
- LB 0x20 with rsp_ready held low 4 cycles -> rsp_valid/rsp_data 0x00EF stable throughout; req_ready 0 until the cycle after rsp_ready rises.
- SH 0x40 wdata 0xCAFE with reset asserted during BYTE0 -> mem[0x40] = 0xFE, mem[0x41] unchanged, all outputs at reset values, req_ready 1 after reset.
- req_valid held during LH -> second request accepted only on IDLE return, no duplicate accept; memory address sequence observed is 0x20, 0x21, then the next request's address.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the memory-access stage: op encodings, FSM states
// and the data-memory geometry.
package lsu_pkg;

    localparam int MEM_DEPTH = 256;

    typedef enum logic [1:0] {
        LSU_LB = 2'b00,
        LSU_SB = 2'b01,
        LSU_LH = 2'b10,
        LSU_SH = 2'b11
    } lsu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BYTE0 = 2'd1,
        BYTE1 = 2'd2,
        RESP  = 2'd3
    } lsu_state_e;

    function automatic logic op_is_store(input lsu_op_e op);
        return op[0];
    endfunction

    function automatic logic op_is_half(input lsu_op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/load_store_unit.sv
// Memory-access stage: turns one LB/SB/LH/SH request into one or two
// single-byte memory cycles and returns load results over valid/ready.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = $clog2(MEM_DEPTH),
    parameter int REG_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [15:0]       req_wdata,
    input  logic [REG_W-1:0]  req_rd,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [15:0]       rsp_data,
    output logic [REG_W-1:0]  rsp_rd,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [7:0]        mem_datain,
    input  logic [7:0]        mem_dataout
);

    lsu_state_e        state_q;
    lsu_op_e           op_q;
    logic [7:0]        wdata_hi_q;
    logic              mem_write_q;
    logic [ADDR_W-1:0] mem_address_q;
    logic [7:0]        mem_datain_q;
    logic              rsp_valid_q;
    logic [15:0]       rsp_data_q;
    logic [REG_W-1:0]  rsp_rd_q;
    logic [ADDR_W-1:0] addr_hi_d;

    // mem_address still holds the low-byte address during BYTE0; wraps at the top.
    assign addr_hi_d = mem_address_q + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            mem_write_q   <= 1'b0;
            mem_address_q <= '0;
            mem_datain_q  <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_rd_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        op_q          <= lsu_op_e'(req_op);
                        wdata_hi_q    <= req_wdata[15:8];
                        rsp_rd_q      <= req_rd;
                        mem_address_q <= req_addr;
                        mem_write_q   <= req_op[0];
                        mem_datain_q  <= req_wdata[7:0];
                        state_q       <= BYTE0;
                    end
                end
                BYTE0: begin
                    if (!op_is_store(op_q)) begin
                        rsp_data_q <= {8'h00, mem_dataout};
                    end
                    if (op_is_half(op_q)) begin
                        mem_address_q <= addr_hi_d;
                        mem_datain_q  <= wdata_hi_q;
                        state_q       <= BYTE1;
                    end else begin
                        mem_write_q <= 1'b0;
                        if (op_is_store(op_q)) begin
                            state_q <= IDLE;
                        end else begin
                            rsp_valid_q <= 1'b1;
                            state_q     <= RESP;
                        end
                    end
                end
                BYTE1: begin
                    mem_write_q <= 1'b0;
                    if (op_is_store(op_q)) begin
                        state_q <= IDLE;
                    end else begin
                        rsp_data_q[15:8] <= mem_dataout;
                        rsp_valid_q      <= 1'b1;
                        state_q          <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_rd      = rsp_rd_q;
    assign mem_write   = mem_write_q;
    assign mem_address = mem_address_q;
    assign mem_datain  = mem_datain_q;

endmodule
